mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//   Iterative multiply/divide unit for the MIPS datapath: MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO writes.
//   Sits beside the ALU, sourced from the register-file read ports. The control unit stalls the pipeline on busy_o.
//   Radix-2, one result bit per clock; WIDTH generalises the datapath beyond 32 bits.
// PARAMETERS
//   WIDTH   32   operand width; HI and LO are WIDTH bits each; must be >= 4.
//   CNT_W   $clog2(WIDTH)+1   iteration counter width (derived; do not override).
// PORTS
//   clk_i        in   1      clock, rising edge
//   rst_i        in   1      asynchronous reset, active low
//   start_i      in   1      start request; sampled only in IDLE
//   op_i         in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a_i          in   WIDTH  multiplicand / dividend (rs)
//   b_i          in   WIDTH  multiplier / divisor (rt)
//   abort_i      in   1      cancel the operation in flight (pipeline flush)
//   hilo_we_i    in   1      direct HI/LO write (MTHI/MTLO)
//   hilo_sel_i   in   1      0 writes LO, 1 writes HI
//   hilo_data_i  in   WIDTH  direct write data
//   busy_o       out  1      operation in flight (RUN or FIX)
//   done_o       out  1      one-cycle pulse; hi_o/lo_o hold the new result in that cycle
//   hi_o         out  WIDTH  HI register (product high half / remainder)
//   lo_o         out  WIDTH  LO register (product low half / quotient)
// BEHAVIOUR
//   Reset (rst_i=0, asynchronous): state IDLE, busy_o=0, done_o=0, hi_o=0, lo_o=0, counter=0.
//   FSM:
//     IDLE -> RUN on start_i. Latches operand magnitudes and sign flags, clears the accumulator.
//     RUN  -> FIX after exactly WIDTH iterations.
//     FIX  -> IDLE. Applies sign correction, writes hi_o/lo_o, and registers done_o=1 for one cycle.
//   Latency: start sampled at edge t; done_o high in the cycle after edge t+WIDTH+1 (34 edges for WIDTH=32).
//     Latency is fixed and does not depend on the data.
//   busy_o is high from edge t to edge t+WIDTH+1. It is low in the done_o cycle, so back-to-back starts are legal.
//   Multiply: shift-add over a 2*WIDTH product; {hi,lo} = a*b.
//   Divide: restoring division; lo = quotient, hi = remainder.
//   Signed ops: operate on magnitudes, then in FIX:
//     product negated if sign(a)^sign(b);
//     quotient negated if sign(a)^sign(b);
//     remainder takes the sign of a.
//   Divide by zero (b_i=0, any divide op): lo = all ones, hi = a_i as given. Same latency, no error flag.
//   Signed MIN / -1: lo = MIN, hi = 0 (two's-complement wrap, no trap).
//   start_i while busy_o=1: ignored; no queueing.
//   abort_i in RUN/FIX: next edge -> IDLE, busy_o=0, no done_o, hi_o/lo_o unchanged. abort_i in IDLE: no effect.
//   hilo_we_i: honoured only in IDLE (ignored when busy).
//     Same-cycle hilo_we_i and start_i in IDLE: the write is applied, then the start proceeds normally.
//     The operation's FIX result later overwrites the written register.
//   Async reset mid-operation: immediate IDLE, all outputs cleared, no done_o.
// CONFIGURATION
//   MDU_SIGNED_EN defined: op_i[0]=1 selects signed MULT/DIV as described above.
//   MDU_SIGNED_EN undefined: op_i[0] ignored; all ops unsigned.
//     Sign capture and sign-correction logic are removed.
//     The FIX state is kept, so latency is identical in both builds.
// TESTING (WIDTH=32)
//   1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done_o exactly 34 edges after start; busy_o low in the done cycle.
//   2. MULT 0xFFFFFFFD*0x00000007:
//        with MDU_SIGNED_EN -> hi=0xFFFFFFFF, lo=0xFFFFFFEB;
//        without it -> hi=0x00000006, lo=0xFFFFFFEB.
//   3. DIVU 100/7 -> lo=14, hi=2.
//      DIV 0xFFFFFFF9/2 (signed) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   4. DIVU 0x00001234/0 -> lo=0xFFFFFFFF, hi=0x00001234, normal latency.
//   5. Start MULTU; pulse start_i at RUN cycle 5 with other operands; assert abort_i at RUN cycle 10:
//        second start ignored; busy_o falls next edge; no done_o; hi/lo keep prior values.
//   6. MTLO 0xA5A5A5A5 in IDLE -> lo_o=0xA5A5A5A5 next edge; MTHI while busy -> ignored.
//      rst_i low mid-RUN -> all outputs 0 immediately, no done_o.

Source files
------------

// File: rtl/mul_div_unit.sv
// Radix-2 iterative multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Define MDU_SIGNED_EN to enable signed MULT/DIV via op_i[0]; otherwise every op is unsigned.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  input  logic             hilo_we_i,
  input  logic             hilo_sel_i,
  input  logic [WIDTH-1:0] hilo_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_q, div_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rs;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

`ifdef MDU_SIGNED_EN
  logic negp_q, negp_d;
  logic negr_q, negr_d;
  logic a_neg, b_neg;

  assign a_neg = op_i[0] & a_i[WIDTH-1];
  assign b_neg = op_i[0] & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;
`else
  logic unused_sign;

  assign unused_sign = op_i[0];
  assign a_mag = a_i;
  assign b_mag = b_i;
`endif

  // Shift-add keeps the product in {acc, q}; restoring divide shifts q into acc.
  assign mul_sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
  assign div_rs   = {acc_q, q_q[WIDTH-1]};
  assign div_diff = div_rs - {1'b0, b_q};

  always_comb begin
    prod = {acc_q, q_q};
    quo  = q_q;
    rem  = acc_q;
`ifdef MDU_SIGNED_EN
    if (negp_q) begin
      prod = -prod;
      quo  = -quo;
    end
    if (negr_q) rem = -rem;
`endif
    if (dz_q) quo = '1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
`ifdef MDU_SIGNED_EN
    negp_d  = negp_q;
    negr_d  = negr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (hilo_we_i) begin
          if (hilo_sel_i) hi_d = hilo_data_i;
          else            lo_d = hilo_data_i;
        end
        if (start_i) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
          q_d     = a_mag;
          b_d     = b_mag;
          div_d   = op_i[1];
          dz_d    = op_i[1] & (b_i == '0);
`ifdef MDU_SIGNED_EN
          negp_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
`endif
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          if (div_q) begin
            q_d = {q_q[WIDTH-2:0], ~div_diff[WIDTH]};
            acc_d = div_diff[WIDTH] ? div_rs[WIDTH-1:0]
                                    : div_diff[WIDTH-1:0];
          end else begin
            acc_d = mul_sum[WIDTH:1];
            q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!abort_i) begin
          done_d = 1'b1;
          if (div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

`ifdef MDU_SIGNED_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      negp_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negp_q <= negp_d;
      negr_q <= negr_d;
    end
  end
`endif

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
